// File: rtl/flodac_spi.sv
// SPI DAC frame transmitter: {PREFIX, data_i} shifted out MSB first, CPOL=0.
// Optional LDAC load pulse after each frame is enabled by FLODAC_SPI_LDAC_EN.
module flodac_spi #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [7:0]  PREFIX  = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        stb_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        ss_n_o,
  output logic        busy_o,
  output logic        err_o
`ifdef FLODAC_SPI_LDAC_EN
  ,
  output logic        ldac_n_o
`endif
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("flodac_spi: CLK_DIV must be in 1..255");
  end

  localparam logic [7:0] PH_MAX = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_HOLD  = 3'd2,
`ifdef FLODAC_SPI_LDAC_EN
    S_LDAC  = 3'd3,
`endif
    S_GAP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [4:0]  bit_q, bit_d;
  logic        hi_q, hi_d;
  logic [23:0] frame_q, frame_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        ss_n_q, ss_n_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        ph_end;
  logic [4:0]  bit_idx;
`ifdef FLODAC_SPI_LDAC_EN
  logic        ldac_n_q, ldac_n_d;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    frame_d = frame_q;
    ph_end  = (phase_q == PH_MAX);

    if (state_q != S_IDLE) begin
      phase_d = ph_end ? 8'd0 : phase_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (stb_i && !busy_q) begin
          state_d = S_SHIFT;
          frame_d = {PREFIX, data_i};
          phase_d = 8'd0;
          bit_d   = 5'd0;
          hi_d    = 1'b0;
        end
      end
      S_SHIFT: begin
        // each bit: D cycles low then D cycles high
        if (ph_end) begin
          if (!hi_q) begin
            hi_d = 1'b1;
          end else begin
            hi_d = 1'b0;
            if (bit_q == 5'd23) state_d = S_HOLD;
            else                bit_d   = bit_q + 5'd1;
          end
        end
      end
      S_HOLD: begin
`ifdef FLODAC_SPI_LDAC_EN
        if (ph_end) state_d = S_LDAC;
`else
        if (ph_end) state_d = S_GAP;
`endif
      end
`ifdef FLODAC_SPI_LDAC_EN
      S_LDAC: begin
        if (ph_end) state_d = S_GAP;
      end
`endif
      S_GAP: begin
        if (ph_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are decoded from the next state so they appear registered
    bit_idx = 5'd23 - bit_d;
    sclk_d  = (state_d == S_SHIFT) && hi_d;
    mosi_d  = (state_d == S_IDLE) ? 1'b0 : frame_d[bit_idx];
    ss_n_d  = !((state_d == S_SHIFT) || (state_d == S_HOLD));
    busy_d  = (state_d != S_IDLE);
    err_d   = stb_i && busy_q;
`ifdef FLODAC_SPI_LDAC_EN
    ldac_n_d = (state_d != S_LDAC);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= 8'd0;
      bit_q    <= 5'd0;
      hi_q     <= 1'b0;
      frame_q  <= 24'd0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ss_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef FLODAC_SPI_LDAC_EN
      ldac_n_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      hi_q     <= hi_d;
      frame_q  <= frame_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ss_n_q   <= ss_n_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef FLODAC_SPI_LDAC_EN
      ldac_n_q <= ldac_n_d;
`endif
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign ss_n_o = ss_n_q;
  assign busy_o = busy_q;
  assign err_o  = err_q;
`ifdef FLODAC_SPI_LDAC_EN
  assign ldac_n_o = ldac_n_q;
`endif

endmodule
